dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

MEM-stage data-cache controller of the pipelined MIPS CPU: a direct-mapped, write-back, write-allocate L1 data cache between the EX/MEM pipeline register and the off-chip data memory. It serves loads and stores from the pipeline, stalls the whole pipeline on a miss, and runs the dirty-writeback and refill handshake with memory. Its load data and stall output feed the MEM/WB pipeline register and the hazard logic.

## Interface
- Parameters: none. Geometry is fixed by package constants: 32 lines, 32-byte blocks, 1 KiB total.
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request; wins if both requests are high
- p1_addr_i  in  32  byte address: tag [31:10], index [9:5], word [4:2]; [1:0] ignored
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data, valid while the request is high and p1_stall_o is low
- p1_stall_o  out  1  pipeline stall
- mem_enable_o  out  1  memory request strobe
- mem_write_o  out  1  1 = writeback, 0 = refill
- mem_addr_o  out  32  block-aligned address, bits [4:0] = 0
- mem_data_o  out  256  writeback block
- mem_data_i  in  256  refill block
- mem_ack_i  in  1  one-cycle completion pulse from memory
- hit_cnt_o, miss_cnt_o  out  32 each  statistics counters (see Configuration)

## Operation
- Per line: valid, dirty, 22-bit tag, 256-bit data.
- hit = valid & (tag == p1_addr_i[31:10]) at index p1_addr_i[9:5].
- Read hit: p1_data_o is the selected word, combinational from the array. No stall.
- Write hit: the selected word is merged at posedge and dirty is set. No stall.
- No request: the array is not changed and p1_data_o = 0.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE: request and miss -> WRITEBACK if the victim is valid and dirty, else REFILL. The request address is latched.
- WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim block. On mem_ack_i -> REFILL.
- REFILL: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {latched tag, index, 5'b0}. On mem_ack_i: write mem_data_i into the line, set valid, clear dirty, update the tag, go to IDLE.
- After REFILL, the replayed access hits in IDLE. A store then merges and sets dirty.
- p1_stall_o = (state != IDLE) | (request & ~hit).
- Request inputs must stay stable while p1_stall_o is high. The controller uses the latched address regardless.
- mem_ack_i is ignored in IDLE.

## Timing
- Reset: state = IDLE, all valid and dirty bits = 0, counters = 0.
- Outputs under reset: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
- p1_stall_o follows its combinational rule; right after reset it is 1 on any request, because every line is invalid.
- Hit: zero added latency. The store commits at the posedge ending the access cycle.
- Clean miss, miss detected in cycle 0:
  - cycle 1: REFILL, mem_enable_o high
  - held high until the ack cycle
  - the cycle after the ack: IDLE, hit, p1_stall_o low
- Dirty miss: WRITEBACK first, then the same REFILL sequence. Total = both ack latencies + 2 cycles of stall.
- mem_enable_o drops the cycle after mem_ack_i. Memory must not ack without enable.
- Reset mid-miss aborts the transaction: mem_enable_o is 0 in the next cycle. Memory must tolerate the abandoned request, and the line stays invalid.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_cnt_o increments once per request that hits in IDLE, including the replay after a refill.
  - miss_cnt_o increments once per miss entry (IDLE -> WRITEBACK/REFILL).
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on rst_i.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package dcache_pkg holds:
  - the state enum
  - constants for line count (32), block bits (256), tag width (22), index [9:5] and word [4:2] bit ranges
- Sub-module dcache_sram: tag/valid/dirty/data array with one synchronous write port and a combinational read port.

## Test plan
- After reset, load 0x0000_0040 -> stall; REFILL with mem_addr_o = 0x40; ack with word 0 = 0xDEADBEEF; next cycle p1_data_o = 0xDEADBEEF, stall low.
- Store 0x12345678 to 0x44 on a resident line -> no stall; a following load of 0x44 returns 0x12345678.
- Load 0x0000_0440 (same index 2, different tag) after the dirty store -> WRITEBACK of block 0x40 carrying word 1 = 0x12345678, then REFILL of 0x440.
- Memory ack delayed 10 cycles -> mem_enable_o and p1_stall_o held for all 10 cycles; mem_enable_o low the cycle after the ack.
- rst_i asserted during REFILL -> next cycle IDLE, mem_enable_o = 0; reload 0x40 misses again.
- With DCACHE_STATS_EN, for 3 misses then 5 hits: miss_cnt_o = 3, hit_cnt_o = 8 (the 3 replays plus the 5 hits).

Source files
------------

// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared constants, types and helpers for the MEM-stage L1 data cache.
// Geometry: 32 direct-mapped lines of 32 bytes (1 KiB). Byte address split:
//   tag [31:10], index [9:5], word [4:2], byte [1:0] (ignored).
// ---------------------------------------------------------------------------
package dcache_pkg;

  localparam int NUM_LINES  = 32;
  localparam int BLOCK_BITS = 256;
  localparam int TAG_W      = 22;
  localparam int INDEX_W    = 5;
  localparam int WORD_W     = 3;

  localparam int TAG_LO   = 10;
  localparam int INDEX_HI = 9;
  localparam int INDEX_LO = 5;
  localparam int WORD_HI  = 4;
  localparam int WORD_LO  = 2;

  // Block address = tag + index (byte address without the in-block offset).
  localparam int BLK_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_e;

  // Word w of a block lives at bits [32*w +: 32].
  function automatic logic [31:0] get_word(input logic [BLOCK_BITS-1:0] blk,
                                           input logic [WORD_W-1:0]     sel);
    return blk[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [BLOCK_BITS-1:0] merge_word(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [WORD_W-1:0]     sel,
                                                       input logic [31:0]           w);
    logic [BLOCK_BITS-1:0] r;
    r = blk;
    r[{sel, 5'b0} +: 32] = w;
    return r;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// ---------------------------------------------------------------------------
// dcache_sram
// Line storage: valid/dirty flags (resettable flops) plus tag and data
// arrays (no reset; gated by valid). One combinational read port and one
// synchronous write port that rewrites a whole line.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (clears flags)
//   rd_idx_i               read index
//   rd_valid_o/rd_dirty_o  flags of the read line
//   rd_tag_o, rd_data_o    tag and block of the read line
//   we_i, wr_idx_i         write strobe and index
//   wr_valid_i, wr_dirty_i, wr_tag_i, wr_data_i   new line contents
// ---------------------------------------------------------------------------
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [BLOCK_BITS-1:0] rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_W-1:0]    wr_idx_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_dirty_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [BLOCK_BITS-1:0] wr_data_i
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_mem [NUM_LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate L1 data cache controller for the
// MEM stage. Hits complete with no stall; misses stall the pipeline while the
// FSM (IDLE -> [WRITEBACK ->] REFILL -> IDLE) moves blocks to/from memory.
// Optional macro DCACHE_STATS_EN builds 32-bit hit/miss counters; without it
// hit_cnt_o/miss_cnt_o are tied to 0.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   p1_MemRead_i, p1_MemWrite_i   pipeline load/store request (store wins)
//   p1_addr_i, p1_data_i          byte address, store data
//   p1_data_o, p1_stall_o         load data, pipeline stall
//   mem_enable_o, mem_write_o     memory strobe, 1 = writeback / 0 = refill
//   mem_addr_o, mem_data_o        block-aligned address, writeback block
//   mem_data_i, mem_ack_i         refill block, one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o         statistics counters
// ---------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p1_MemRead_i,
  input  logic                  p1_MemWrite_i,
  input  logic [31:0]           p1_addr_i,
  input  logic [31:0]           p1_data_i,
  output logic [31:0]           p1_data_o,
  output logic                  p1_stall_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [31:0]           mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_data_o,
  input  logic [BLOCK_BITS-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  state_e                state_q, state_d;
  logic [BLK_ADDR_W-1:0] blk_addr_q, blk_addr_d;

  logic                  req, hit;
  logic [INDEX_W-1:0]    rd_idx;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_BITS-1:0] rd_data;
  logic                  we, wr_valid, wr_dirty;
  logic [TAG_W-1:0]      wr_tag;
  logic [BLOCK_BITS-1:0] wr_data;

  // Byte offset within a word is not used by a word-wide cache.
  logic addr_byte_unused;
  assign addr_byte_unused = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;

  // While a miss is in flight the latched index keeps the victim line
  // selected even if the pipeline address were to wander.
  assign rd_idx = (state_q == S_IDLE) ? p1_addr_i[INDEX_HI:INDEX_LO]
                                      : blk_addr_q[INDEX_W-1:0];

  assign hit        = rd_valid & (rd_tag == p1_addr_i[31:TAG_LO]);
  assign p1_stall_o = (state_q != S_IDLE) | (req & ~hit);

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (we),
    .wr_idx_i   (rd_idx),
    .wr_valid_i (wr_valid),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      blk_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      blk_addr_q <= blk_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    blk_addr_d   = blk_addr_q;
    we           = 1'b0;
    wr_valid     = 1'b0;
    wr_dirty     = 1'b0;
    wr_tag       = rd_tag;
    wr_data      = rd_data;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    p1_data_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            p1_data_o = get_word(rd_data, p1_addr_i[WORD_HI:WORD_LO]);
            if (p1_MemWrite_i) begin
              we       = 1'b1;
              wr_valid = 1'b1;
              wr_dirty = 1'b1;
              wr_data  = merge_word(rd_data, p1_addr_i[WORD_HI:WORD_LO], p1_data_i);
            end
          end else begin
            blk_addr_d = p1_addr_i[31:INDEX_LO];
            state_d    = (rd_valid & rd_dirty) ? S_WRITEBACK : S_REFILL;
          end
        end
      end

      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, blk_addr_q[INDEX_W-1:0], 5'b0};
        mem_data_o   = rd_data;
        if (mem_ack_i) state_d = S_REFILL;
      end

      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {blk_addr_q, 5'b0};
        if (mem_ack_i) begin
          we       = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_tag   = blk_addr_q[BLK_ADDR_W-1:INDEX_W];
          wr_data  = mem_data_i;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Keep the memory interface quiet while reset is held, even if the
    // registered state has not been cleared yet.
    if (rst_i) begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      we           = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // A miss is counted on entry; the replay after the refill counts as a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_IDLE && req) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
// Directed bench for dcache_ctrl: table-driven hit vectors plus hand-written
// miss, dirty-writeback, delayed-ack, reset-abort and statistics sequences.
// Memory acks are driven by hand so that every latency is known in advance.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  int total = 0;
  int bad   = 0;

`ifdef DCACHE_STATS_EN
  localparam logic [31:0] EXP_HITS = 32'd8;
  localparam logic [31:0] EXP_MISS = 32'd3;
`else
  localparam logic [31:0] EXP_HITS = 32'd0;
  localparam logic [31:0] EXP_MISS = 32'd0;
`endif

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];
  vec_t hits [5];

  logic [255:0] blk_a, wb_blk, blk_b, blk_c, blk_d, blk_e;

  function automatic logic [255:0] mk_blk(input logic [31:0] hi);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = hi | w;
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each cycle starts 1 time unit after the rising edge; checks at +5.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    set_req(v.rd, v.wr, v.addr, v.wdata);
    #4;
    chk($sformatf("vec%0d_stall", idx), p1_stall_o, 0);
    chk($sformatf("vec%0d_en", idx), mem_enable_o, 0);
    if (v.chk_data) chk($sformatf("vec%0d_data", idx), p1_data_o, v.exp_data);
    $display("vec %0d rd=%0b wr=%0b addr=%08h data=%08h stall=%0b",
             idx, v.rd, v.wr, v.addr, p1_data_o, p1_stall_o);
    cyc();
  endtask

  // Request already applied; checks the IDLE miss cycle and enters the FSM.
  task automatic miss_start(input string name);
    #4;
    chk({name, "_miss_stall"}, p1_stall_o, 1);
    chk({name, "_miss_en"}, mem_enable_o, 0);
    cyc();
  endtask

  task automatic wb_phase(input logic [31:0] vaddr, input logic [255:0] vblk, input int delay);
    for (int i = 0; i <= delay; i++) begin
      #4;
      chk("wb_en", mem_enable_o, 1);
      chk("wb_write", mem_write_o, 1);
      chk("wb_stall", p1_stall_o, 1);
      chk("wb_addr", mem_addr_o, vaddr);
      chk("wb_data", mem_data_o, vblk);
      if (i == delay) mem_ack_i = 1'b1;
      cyc();
    end
    mem_ack_i = 1'b0;
    $display("writeback addr=%08h delay=%0d", vaddr, delay);
  endtask

  task automatic refill_phase(input logic [31:0] addr, input logic [255:0] blk, input int delay);
    for (int i = 0; i <= delay; i++) begin
      #4;
      chk("refill_en", mem_enable_o, 1);
      chk("refill_write", mem_write_o, 0);
      chk("refill_stall", p1_stall_o, 1);
      chk("refill_addr", mem_addr_o, addr);
      if (i == delay) begin
        mem_ack_i  = 1'b1;
        mem_data_i = blk;
      end
      cyc();
    end
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #4;
    chk("post_ack_en", mem_enable_o, 0);
    chk("post_ack_stall", p1_stall_o, 0);
    $display("refill addr=%08h delay=%0d", addr, delay);
  endtask

  initial begin
    blk_a = mk_blk(32'hA000_0000);
    blk_a[31:0] = 32'hDEAD_BEEF;
    wb_blk = blk_a;
    wb_blk[63:32]    = 32'h1234_5678;
    wb_blk[255:224]  = 32'hCAFE_F00D;
    blk_b = mk_blk(32'hB000_0000);
    blk_c = mk_blk(32'hC000_0000);
    blk_d = mk_blk(32'hD000_0000);
    blk_e = mk_blk(32'hE000_0000);

    vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,          1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b1, 32'hA000_0001};
    vecs[2] = '{1'b0, 1'b1, 32'h44, 32'h1234_5678,  1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'h47, 32'h0,          1'b1, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h5C, 32'h0,          1'b1, 32'hA000_0007};
    vecs[6] = '{1'b1, 1'b1, 32'h5C, 32'hCAFE_F00D,  1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h5C, 32'h0,          1'b1, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 1'b0, 32'h5C, 32'h0,          1'b1, 32'h0};

    hits[0] = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b1, 32'hC000_0001};
    hits[1] = '{1'b1, 1'b0, 32'h9C, 32'h0,          1'b1, 32'hD000_0007};
    hits[2] = '{1'b0, 1'b1, 32'hC4, 32'h55AA_55AA,  1'b0, 32'h0};
    hits[3] = '{1'b1, 1'b0, 32'hC4, 32'h0,          1'b1, 32'h55AA_55AA};
    hits[4] = '{1'b1, 1'b0, 32'h40, 32'h0,          1'b1, 32'hC000_0000};

    rst_i      = 1'b1;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    #4;
    chk("rst_en", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    cyc();
    rst_i = 1'b0;
    #4;
    chk("idle_stall", p1_stall_o, 0);
    chk("idle_data", p1_data_o, 0);
    chk("idle_hits", hit_cnt_o, 0);
    chk("idle_miss", miss_cnt_o, 0);
    $display("reset released");
    cyc();

    // Cold miss on 0x40, ack in the first REFILL cycle.
    set_req(1'b1, 1'b0, 32'h40, 32'h0);
    miss_start("cold");
    refill_phase(32'h40, blk_a, 0);
    chk("cold_replay_data", p1_data_o, 32'hDEAD_BEEF);
    cyc();

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

    // Dirty victim at index 2: writeback of 0x40, then 10-cycle refill of 0x440.
    set_req(1'b1, 1'b0, 32'h440, 32'h0);
    miss_start("dirty");
    wb_phase(32'h40, wb_blk, 2);
    refill_phase(32'h440, blk_b, 10);
    chk("dirty_replay_data", p1_data_o, 32'hB000_0000);
    cyc();

    // Freshly refilled line is clean: going back to 0x40 skips writeback.
    set_req(1'b1, 1'b0, 32'h40, 32'h0);
    miss_start("clean");
    refill_phase(32'h40, wb_blk, 1);
    chk("clean_replay_data", p1_data_o, 32'hDEAD_BEEF);
    cyc();

    // Reset while refilling 0x80.
    set_req(1'b1, 1'b0, 32'h80, 32'h0);
    miss_start("abort");
    #4;
    chk("abort_refill_en", mem_enable_o, 1);
    chk("abort_refill_addr", mem_addr_o, 32'h80);
    rst_i = 1'b1;
    #1;
    chk("abort_rst_en", mem_enable_o, 0);
    chk("abort_rst_addr", mem_addr_o, 0);
    cyc();
    rst_i = 1'b0;
    set_req(1'b1, 1'b0, 32'h40, 32'h0);
    #4;
    chk("after_rst_en", mem_enable_o, 0);
    chk("after_rst_stall", p1_stall_o, 1);
    chk("after_rst_hits", hit_cnt_o, 0);
    chk("after_rst_miss", miss_cnt_o, 0);
    $display("reset during refill");
    cyc();

    // Three clean misses, each followed by its replay hit, then five hits.
    refill_phase(32'h40, blk_c, 0);
    chk("m1_replay_data", p1_data_o, 32'hC000_0000);
    cyc();
    set_req(1'b1, 1'b0, 32'h84, 32'h0);
    miss_start("m2");
    refill_phase(32'h80, blk_d, 3);
    chk("m2_replay_data", p1_data_o, 32'hD000_0001);
    cyc();
    set_req(1'b1, 1'b0, 32'hC8, 32'h0);
    miss_start("m3");
    refill_phase(32'hC0, blk_e, 0);
    chk("m3_replay_data", p1_data_o, 32'hE000_0002);
    cyc();
    for (int i = 0; i < 5; i++) apply_vec(hits[i], 9 + i);

    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    #4;
    chk("stats_hits", hit_cnt_o, EXP_HITS);
    chk("stats_miss", miss_cnt_o, EXP_MISS);
    $display("stats hits=%0d misses=%0d", hit_cnt_o, miss_cnt_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
